word_unpacker: RTL and testbench
================================

# word_unpacker

Width converter that rebuilds 40-bit ETROC2 frames from a 32-bit word stream, MSB-first. It is the receive-side counterpart of the 40→32 packer on the readout path. It sits between the 32-bit DAQ/link FIFO and the 40-bit frame decoder in test firmware and emulation. It uses a 128-bit circular bit buffer with valid/ready handshakes on both sides, plus a flush input to discard residual or padding bits at stream boundaries.

## Interface
Parameters (fixed in package, not overridable):
- IN_W, 32, input word width
- OUT_W, 40, output frame width
- BUF_W, 128, circular buffer depth in bits

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  40 MHz system clock
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input word valid
- s_ready  out  1  buffer can accept a 32-bit word
- s_data  in  32  input word; bit 31 is the earliest bit
- m_valid  out  1  a complete 40-bit frame is available
- m_ready  in  1  downstream accepts the frame
- m_data  out  40  output frame; bit 39 is the earliest bit
- flush  in  1  synchronous; discards all buffered bits
- bits_count  out  8  buffered bits, 0..128

## Operation
- State registers:
  - cb[127:0]
  - wr_ptr[6:0], rd_ptr[6:0] (both wrap mod 128)
  - count[7:0]
- Input accept: s_valid && s_ready. Write cb[(wr_ptr+i)%128] <= s_data[31-i] for i = 0..31, then wr_ptr += 32.
- Output read: m_data[39-i] = cb[(rd_ptr+i)%128] for i = 0..39. This is combinational from registers.
- Output accept: m_valid && m_ready. rd_ptr += 40.
- s_ready = !rst && !flush && (count <= 96). Space for a full word is guaranteed, so no overflow is possible.
- m_valid = !rst && !flush && (count >= 40). When m_valid = 0, m_data is forced to 0.
- count_next = count + 32·in_fire − 40·out_fire. Compute at 9 bits signed; the result is always in 0..128.
- Simultaneous accept on both sides is legal in the same cycle. The read uses the pre-write rd_ptr and count, so the write does not bypass into the read.
- flush: clears wr_ptr, rd_ptr and count to 0 at the next edge. Any handshake in that cycle is void; both ready and valid are low, so nothing fires. cb contents are not cleared.
- Residual bits (count < 40) stay buffered until more input arrives or flush is asserted. Trailing zero padding from the packer is removed with flush.
- bits_count = count.

## Timing
- Reset (asynchronous assert): wr_ptr, rd_ptr and count are 0. Outputs are s_ready 0, m_valid 0, m_data 0, bits_count 0. On the first edge after deassert, s_ready = 1.
- Reset asserted mid-stream: all buffered bits are lost. No partial frame appears afterwards.
- Latency: an input accepted at edge N is reflected in count, m_valid and m_data right after edge N. First frame: two words accepted (count 64) gives m_valid on the cycle after the second accept.
- Throughput: sustained 1 word in/cycle with m_ready held high. Output rate is 4 frames per 5 input words.
- s_ready and m_valid depend only on registers and flush. There is no combinational path from s_valid or m_ready.
- Pointer wrap: the 128 boundary is crossed mid-word or mid-frame without bubbles.

## Structure
- Package word_pack_pkg holds IN_W, OUT_W, BUF_W, PTR_W = 7, CNT_W = 8, and the thresholds READY_MAX = 96 and VALID_MIN = 40. The 40→32 packer shares the same package.
- Natural sub-module: bit_window_read. It is a parameterised rotate-and-extract of OUT_W bits from a circular vector at rd_ptr, with MSB-first mapping. Keep the pointer and count logic in the top module.

## Test plan
- Reset and idle: assert rst mid-cycle, release → s_ready=0 and m_valid=0 during reset. After the edge: s_ready=1, m_valid=0, bits_count=0.
- Ordered stream: feed 5 words 0x01234567, 0x89ABCDEF, 0x01234567, 0x89ABCDEF, 0x01234567 back-to-back with m_ready=1 → frames 0x0123456789, 0xABCDEF0123, 0x456789ABCD, 0xEF01234567. Then bits_count=0.
- Backpressure: m_ready=0 with s_valid=1 → accepts stop at count=128 (4 words, s_ready low). m_valid=1 with m_data=0x0123456789 held stable. Release m_ready → 3 frames drain, input resumes.
- Wrap-around: 10,000 random 40-bit frames packed into a 32-bit stream with random s_valid/m_ready gaps → output matches the scoreboard exactly. Pointers wrap many times.
- Flush residual: feed one word (count 32), assert flush → bits_count=0 and m_valid stays 0. Next words realign to a fresh frame boundary.
- Simultaneous events: at count=64, fire in and out in the same cycle → count 56. Assert flush concurrently with s_valid=1 → the word is not accepted and count=0.

Source files
------------

// File: rtl/word_pack_pkg.sv
// word_pack_pkg
//   Shared constants and types for the 32<->40 bit width converters
//   (word_unpacker on the receive side, the 40->32 packer on readout).
//   Widths are fixed here and are not meant to be overridden per instance.
package word_pack_pkg;

    localparam int unsigned IN_W      = 32;   // input word width
    localparam int unsigned OUT_W     = 40;   // output frame width
    localparam int unsigned BUF_W     = 128;  // circular buffer depth in bits
    localparam int unsigned PTR_W     = 7;    // log2(BUF_W)
    localparam int unsigned CNT_W     = 8;    // holds 0..BUF_W inclusive

    // Accept a word only while a full word of space remains.
    localparam int unsigned READY_MAX = BUF_W - IN_W;
    // A frame is presentable once a full frame of bits is buffered.
    localparam int unsigned VALID_MIN = OUT_W;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/word_unpacker_bit_window_read.sv
// bit_window_read
//   Extracts WIN_W consecutive bits from a circular bit vector starting at
//   ptr_i, MSB-first: win_o[WIN_W-1-i] = vec_i[(ptr_i + i) mod VEC_W].
//   Purely combinational. VEC_W must equal 2**PTR_W so that the pointer
//   addition wraps naturally.
// Ports
//   vec_i  in   VEC_W  circular bit vector
//   ptr_i  in   PTR_W  index of the earliest bit
//   win_o  out  WIN_W  extracted window, earliest bit in the MSB
module bit_window_read #(
    parameter int unsigned VEC_W = 128,
    parameter int unsigned WIN_W = 40,
    parameter int unsigned PTR_W = 7
) (
    input  logic [VEC_W-1:0] vec_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [WIN_W-1:0] win_o
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        win_o = '0;
        idx   = '0;
        for (int unsigned i = 0; i < WIN_W; i++) begin
            idx                = ptr_i + PTR_W'(i);
            win_o[WIN_W-1-i]   = vec_i[idx];
        end
    end

endmodule

// File: rtl/word_unpacker.sv
// word_unpacker
//   Rebuilds 40-bit frames from a 32-bit word stream, MSB-first, through a
//   128-bit circular bit buffer with valid/ready handshakes on both sides.
//   flush discards all buffered bits (pointers and count return to zero).
// Ports
//   clk         in   1   system clock
//   rst         in   1   asynchronous, active-high reset
//   s_valid     in   1   input word valid
//   s_ready     out  1   a full 32-bit word of space is available
//   s_data      in   32  input word, bit 31 earliest
//   m_valid     out  1   a complete 40-bit frame is buffered
//   m_ready     in   1   downstream accepts the frame
//   m_data      out  40  output frame, bit 39 earliest; zero when !m_valid
//   flush       in   1   synchronous discard of all buffered bits
//   bits_count  out  8   number of buffered bits, 0..128
module word_unpacker
    import word_pack_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    input  logic             flush,
    output logic [CNT_W-1:0] bits_count
);

    localparam logic signed [CNT_W:0] IN_STEP  = (CNT_W+1)'(IN_W);
    localparam logic signed [CNT_W:0] OUT_STEP = (CNT_W+1)'(OUT_W);

    logic [BUF_W-1:0] cb_q, cb_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    cnt_t             count_q, count_d;

    logic              in_fire, out_fire;
    logic [OUT_W-1:0]  window;
    ptr_t              wr_idx;
    logic signed [CNT_W:0] cnt_sum;

    // Handshake flags depend only on registers, rst and flush.
    assign s_ready  = !rst && !flush && (count_q <= CNT_W'(READY_MAX));
    assign m_valid  = !rst && !flush && (count_q >= CNT_W'(VALID_MIN));
    assign in_fire  = s_valid && s_ready;
    assign out_fire = m_valid && m_ready;

    // The read window uses the pre-write rd_ptr/cb, so a same-cycle write
    // never bypasses into the frame being presented.
    bit_window_read #(
        .VEC_W (BUF_W),
        .WIN_W (OUT_W),
        .PTR_W (PTR_W)
    ) u_window (
        .vec_i (cb_q),
        .ptr_i (rd_ptr_q),
        .win_o (window)
    );

    assign m_data     = m_valid ? window : '0;
    assign bits_count = count_q;

    // Scatter the incoming word into the circular buffer, earliest bit first.
    always_comb begin
        cb_d   = cb_q;
        wr_idx = '0;
        if (in_fire) begin
            for (int unsigned i = 0; i < IN_W; i++) begin
                wr_idx       = wr_ptr_q + PTR_W'(i);
                cb_d[wr_idx] = s_data[IN_W-1-i];
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_sum  = $signed({1'b0, count_q});
        if (in_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(IN_W);
            cnt_sum  = cnt_sum + IN_STEP;
        end
        if (out_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(OUT_W);
            cnt_sum  = cnt_sum - OUT_STEP;
        end
        count_d = cnt_sum[CNT_W-1:0];
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Buffer contents are meaningless without the pointers, so no reset.
    always_ff @(posedge clk) begin
        cb_q <= cb_d;
    end

endmodule

// File: tb/tb_word_unpacker.sv
module tb_word_unpacker;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [39:0] m_data;
    logic        flush;
    logic [7:0]  bits_count;

    int errors = 0;
    int checks = 0;
    logic [39:0] exp_q[$];
    int frame_no = 0;
    bit rand_on = 0;

    word_unpacker dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .flush      (flush),
        .bits_count (bits_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Inputs change at posedge+1, so negedge sees the values that the next
    // posedge will act on.
    always @(negedge clk) begin
        if (!rst && m_valid === 1'b1 && m_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame got=%h required=none", m_data);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    errors++;
                    $display("FAIL frame[%0d] got=%h required=%h", frame_no, m_data, e);
                end
            end
            frame_no++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_on) m_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a word and returns at posedge+1 after it was accepted;
    // s_valid is left high so back-to-back calls stream without gaps.
    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 0;
        s_valid = 1;
        s_data  = w;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            ok = s_ready;
            step();
            if (ok) break;
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL send_timeout got=not_accepted required=accepted word=%h", w);
        end
    endtask

    task automatic do_flush();
        flush = 1;
        @(negedge clk);
        chk("flush_s_ready", {63'd0, s_ready}, 64'd0);
        chk("flush_m_valid", {63'd0, m_valid}, 64'd0);
        step();
        flush = 0;
        @(negedge clk);
        chk("flush_count", {56'd0, bits_count}, 64'd0);
        step();
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [159:0] blk;
        logic [39:0]  f0, f1, f2, f3;

        rst = 1; s_valid = 0; s_data = '0; m_ready = 0; flush = 0;

        // Reset and idle
        #3;
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_m_data",  {24'd0, m_data}, 64'd0);
        chk("rst_count",   {56'd0, bits_count}, 64'd0);
        @(negedge clk);
        rst = 0;
        step();
        chk("idle_s_ready", {63'd0, s_ready}, 64'd1);
        chk("idle_m_valid", {63'd0, m_valid}, 64'd0);
        chk("idle_count",   {56'd0, bits_count}, 64'd0);

        // Ordered stream
        m_ready = 1;
        exp_q.push_back(40'h0123456789);
        exp_q.push_back(40'hABCDEF0123);
        exp_q.push_back(40'h456789ABCD);
        exp_q.push_back(40'hEF01234567);
        send_word(32'h01234567);
        send_word(32'h89ABCDEF);
        send_word(32'h01234567);
        send_word(32'h89ABCDEF);
        send_word(32'h01234567);
        s_valid = 0;
        step();
        step();
        @(negedge clk);
        chk("ordered_count", {56'd0, bits_count}, 64'd0);
        chk("ordered_empty", 64'(exp_q.size()), 64'd0);
        step();

        // Backpressure: fill to 128 and hold the head frame
        m_ready = 0;
        send_word(32'h01234567);
        send_word(32'h89ABCDEF);
        send_word(32'h01234567);
        send_word(32'h89ABCDEF);
        s_data = 32'h01234567;
        @(negedge clk);
        chk("bp_count",   {56'd0, bits_count}, 64'd128);
        chk("bp_s_ready", {63'd0, s_ready}, 64'd0);
        chk("bp_m_valid", {63'd0, m_valid}, 64'd1);
        chk("bp_m_data",  {24'd0, m_data}, 64'h0123456789);
        step();
        step();
        @(negedge clk);
        chk("bp_hold_data",  {24'd0, m_data}, 64'h0123456789);
        chk("bp_hold_count", {56'd0, bits_count}, 64'd128);
        step();
        exp_q.push_back(40'h0123456789);
        exp_q.push_back(40'hABCDEF0123);
        exp_q.push_back(40'h456789ABCD);
        exp_q.push_back(40'hEF01234567);
        m_ready = 1;
        send_word(32'h01234567);
        s_valid = 0;
        drain();
        step();
        @(negedge clk);
        chk("bp_final_count", {56'd0, bits_count}, 64'd0);
        step();

        // Flush residual and realign
        send_word(32'hDEADBEEF);
        s_valid = 0;
        @(negedge clk);
        chk("res_count",   {56'd0, bits_count}, 64'd32);
        chk("res_m_valid", {63'd0, m_valid}, 64'd0);
        chk("res_m_data",  {24'd0, m_data}, 64'd0);
        step();
        do_flush();
        @(negedge clk);
        chk("post_flush_m_valid", {63'd0, m_valid}, 64'd0);
        step();
        exp_q.push_back(40'h0123456789);
        send_word(32'h01234567);
        send_word(32'h89ABCDEF);
        s_valid = 0;
        step();
        step();
        @(negedge clk);
        chk("realign_count", {56'd0, bits_count}, 64'd24);
        chk("realign_empty", 64'(exp_q.size()), 64'd0);
        step();
        do_flush();

        // Simultaneous in/out at count 64, then flush against s_valid
        m_ready = 0;
        send_word(32'h01234567);
        send_word(32'h89ABCDEF);
        s_valid = 0;
        @(negedge clk);
        chk("first_valid", {63'd0, m_valid}, 64'd1);
        chk("first_count", {56'd0, bits_count}, 64'd64);
        chk("first_data",  {24'd0, m_data}, 64'h0123456789);
        step();
        exp_q.push_back(40'h0123456789);
        m_ready = 1;
        send_word(32'h01234567);
        m_ready = 0;
        s_valid = 0;
        @(negedge clk);
        chk("simul_count", {56'd0, bits_count}, 64'd56);
        chk("simul_data",  {24'd0, m_data}, 64'hABCDEF0123);
        step();
        s_valid = 1;
        s_data  = 32'hFFFFFFFF;
        flush   = 1;
        @(negedge clk);
        chk("fl_sv_s_ready", {63'd0, s_ready}, 64'd0);
        step();
        flush   = 0;
        s_valid = 0;
        @(negedge clk);
        chk("fl_sv_count",   {56'd0, bits_count}, 64'd0);
        chk("fl_sv_m_valid", {63'd0, m_valid}, 64'd0);
        step();

        // Long random stream with gaps on both sides; pointers wrap often
        rand_on = 1;
        for (int b = 0; b < 2500; b++) begin
            f0 = {$urandom_range(0, 255), $urandom};
            f1 = {$urandom_range(0, 255), $urandom};
            f2 = {$urandom_range(0, 255), $urandom};
            f3 = {$urandom_range(0, 255), $urandom};
            exp_q.push_back(f0);
            exp_q.push_back(f1);
            exp_q.push_back(f2);
            exp_q.push_back(f3);
            blk = {f0, f1, f2, f3};
            for (int w = 0; w < 5; w++) begin
                if ($urandom_range(0, 3) == 0) begin
                    s_valid = 0;
                    step();
                end
                send_word(blk[159 - 32*w -: 32]);
            end
        end
        s_valid = 0;
        @(negedge clk);
        rand_on = 0;
        step();
        m_ready = 1;
        drain();
        step();
        @(negedge clk);
        chk("rand_final_count", {56'd0, bits_count}, 64'd0);
        step();

        // Reset asserted mid-stream loses the buffered bits
        send_word(32'hCAFEF00D);
        s_valid = 0;
        @(negedge clk);
        chk("mid_count", {56'd0, bits_count}, 64'd32);
        #2;
        rst = 1;
        #1;
        chk("mid_rst_count",   {56'd0, bits_count}, 64'd0);
        chk("mid_rst_s_ready", {63'd0, s_ready}, 64'd0);
        @(negedge clk);
        rst = 0;
        step();
        send_word(32'h12345678);
        s_valid = 0;
        step();
        @(negedge clk);
        chk("mid_after_count", {56'd0, bits_count}, 64'd32);
        chk("mid_after_valid", {63'd0, m_valid}, 64'd0);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
